// File: rtl/hazard_ctrl_sb.sv
// Scoreboard hazard controller for a 5-stage pipeline: per-register latency
// countdowns, branch squash with optional tag-based undo, memory freeze, stall counter.
module hazard_ctrl_sb #(
  parameter int          REGW       = 5,
  parameter int          MAX_LAT    = 3,
  parameter int          LOAD_LAT   = 1,
  parameter int          ALU_LAT    = 0,
  parameter int          BR_RESOLVE = 1,
  parameter logic [31:0] STALL_RST  = 32'd0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_wen,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_is_load,
  input  logic            redirect,
  input  logic            ihit,
  input  logic            dmem_req,
  input  logic            dhit,
  output logic            pc_en,
  output logic            fd_stall,
  output logic            fd_flush,
  output logic            de_stall,
  output logic            de_flush,
  output logic            em_stall,
  output logic            em_flush,
  output logic            mw_stall,
  output logic            mw_flush,
  output logic [31:0]     stall_cycles
);
  localparam int NREG = 2**REGW;
  localparam int CW   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  logic [NREG-1:0][CW-1:0] r_cnt, w_cnt_nxt;
  logic                    r_tag_vld;
  logic [REGW-1:0]         r_tag_rd;
  logic [CW-1:0]           r_tag_prev;
  logic [31:0]             r_stall_cycles;

  logic w_freeze, w_hazard, w_issue, w_wr, w_stall_cnt, w_restore;

  assign w_freeze    = dmem_req & ~dhit;
  assign w_hazard    = id_valid &
                       ((id_uses_rs && id_rs != '0 && r_cnt[id_rs] != '0) ||
                        (id_uses_rt && id_rt != '0 && r_cnt[id_rt] != '0));
  assign w_issue     = id_valid & ~w_freeze & ~redirect & ~w_hazard;
  assign w_wr        = w_issue & id_wen & (id_rd != '0);
  assign w_stall_cnt = ~w_freeze & ~redirect & w_hazard;
  assign w_restore   = (BR_RESOLVE == 2) && redirect && r_tag_vld && !w_freeze;

  assign stall_cycles = r_stall_cycles;

  always_comb begin
    pc_en    = 1'b1;
    fd_stall = 1'b0; fd_flush = 1'b0;
    de_stall = 1'b0; de_flush = 1'b0;
    em_stall = 1'b0; em_flush = 1'b0;
    mw_stall = 1'b0; mw_flush = 1'b0;
    if (RST) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1; de_flush = 1'b1; em_flush = 1'b1; mw_flush = 1'b1;
    end else if (w_freeze) begin
      pc_en    = 1'b0;
      fd_stall = 1'b1; de_stall = 1'b1; em_stall = 1'b1; mw_stall = 1'b1;
    end else if (redirect) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = (BR_RESOLVE == 2);
    end else if (w_hazard) begin
      pc_en    = 1'b0;
      fd_stall = 1'b1;
      de_flush = 1'b1;
    end else if (!ihit) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
    end
  end

  // Decrement first, then the new producer's latency, then a squash undo wins.
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 1; i < NREG; i++)
      if (r_cnt[i] != '0) w_cnt_nxt[i] = r_cnt[i] - CW'(1);
    if (w_wr)
      w_cnt_nxt[id_rd] = id_is_load ? CW'(LOAD_LAT) : CW'(ALU_LAT);
    if (w_restore)
      w_cnt_nxt[r_tag_rd] = (r_tag_prev != '0) ? r_tag_prev - CW'(1) : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt          <= '0;
      r_tag_vld      <= 1'b0;
      r_tag_rd       <= '0;
      r_tag_prev     <= '0;
      r_stall_cycles <= STALL_RST;
    end else if (!w_freeze) begin
      r_cnt      <= w_cnt_nxt;
      r_tag_vld  <= (BR_RESOLVE == 2) && w_wr;
      r_tag_rd   <= id_rd;
      r_tag_prev <= r_cnt[id_rd];
      if (w_stall_cnt && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Directed vector bench for hazard_ctrl_sb: three configurations share one
// input stream; each row checks the control vector and stall counter of one instance.
module tb_hazard_ctrl_sb;
  logic       CLK, RST;
  logic       id_valid, id_uses_rs, id_uses_rt, id_wen, id_is_load;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       redirect, ihit, dmem_req, dhit;

  logic        pc_en_w [3], fd_stall_w [3], fd_flush_w [3], de_stall_w [3], de_flush_w [3];
  logic        em_stall_w [3], em_flush_w [3], mw_stall_w [3], mw_flush_w [3];
  logic [31:0] sc_w [3];

  // {pc_en, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_stall, mw_flush}
  localparam logic [8:0] RSTO = 9'b001010101;
  localparam logic [8:0] RUN  = 9'b100000000;
  localparam logic [8:0] HZ   = 9'b010010000;
  localparam logic [8:0] FRZ  = 9'b010101010;
  localparam logic [8:0] RD1  = 9'b101010000;
  localparam logic [8:0] RD2  = 9'b101010100;
  localparam logic [8:0] IMS  = 9'b001000000;

  hazard_ctrl_sb #(.REGW(5), .MAX_LAT(3), .LOAD_LAT(1), .ALU_LAT(0), .BR_RESOLVE(1)) u_a (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_rd(id_rd),
    .id_is_load(id_is_load), .redirect(redirect), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .pc_en(pc_en_w[0]), .fd_stall(fd_stall_w[0]), .fd_flush(fd_flush_w[0]),
    .de_stall(de_stall_w[0]), .de_flush(de_flush_w[0]), .em_stall(em_stall_w[0]),
    .em_flush(em_flush_w[0]), .mw_stall(mw_stall_w[0]), .mw_flush(mw_flush_w[0]),
    .stall_cycles(sc_w[0]));

  hazard_ctrl_sb #(.REGW(5), .MAX_LAT(3), .LOAD_LAT(3), .ALU_LAT(0), .BR_RESOLVE(2)) u_b (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_rd(id_rd),
    .id_is_load(id_is_load), .redirect(redirect), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .pc_en(pc_en_w[1]), .fd_stall(fd_stall_w[1]), .fd_flush(fd_flush_w[1]),
    .de_stall(de_stall_w[1]), .de_flush(de_flush_w[1]), .em_stall(em_stall_w[1]),
    .em_flush(em_flush_w[1]), .mw_stall(mw_stall_w[1]), .mw_flush(mw_flush_w[1]),
    .stall_cycles(sc_w[1]));

  hazard_ctrl_sb #(.REGW(5), .MAX_LAT(3), .LOAD_LAT(3), .ALU_LAT(0), .BR_RESOLVE(1),
                   .STALL_RST(32'hFFFF_FFFE)) u_c (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wen(id_wen), .id_rd(id_rd),
    .id_is_load(id_is_load), .redirect(redirect), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .pc_en(pc_en_w[2]), .fd_stall(fd_stall_w[2]), .fd_flush(fd_flush_w[2]),
    .de_stall(de_stall_w[2]), .de_flush(de_flush_w[2]), .em_stall(em_stall_w[2]),
    .em_flush(em_flush_w[2]), .mw_stall(mw_stall_w[2]), .mw_flush(mw_flush_w[2]),
    .stall_cycles(sc_w[2]));

  typedef struct {
    int          sel;
    logic        rst, v;
    logic [4:0]  rs;
    logic        urs;
    logic [4:0]  rt;
    logic        urt, wen;
    logic [4:0]  rd;
    logic        ld, redir, ih, dreq, dh;
    logic [8:0]  exp;
    logic [31:0] sc;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input int sel, input logic rst, input logic v,
                              input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                              input logic urt, input logic wen, input logic [4:0] rd,
                              input logic ld, input logic redir, input logic ih,
                              input logic dreq, input logic dh,
                              input logic [8:0] exp, input logic [31:0] sc);
    vec_t r;
    r.sel = sel; r.rst = rst; r.v = v; r.rs = rs; r.urs = urs; r.rt = rt; r.urt = urt;
    r.wen = wen; r.rd = rd; r.ld = ld; r.redir = redir; r.ih = ih; r.dreq = dreq;
    r.dh = dh; r.exp = exp; r.sc = sc;
    return r;
  endfunction

  function automatic logic [8:0] ctl(input int s);
    return {pc_en_w[s], fd_stall_w[s], fd_flush_w[s], de_stall_w[s], de_flush_w[s],
            em_stall_w[s], em_flush_w[s], mw_stall_w[s], mw_flush_w[s]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    RST = r.rst; id_valid = r.v; id_rs = r.rs; id_uses_rs = r.urs; id_rt = r.rt;
    id_uses_rt = r.urt; id_wen = r.wen; id_rd = r.rd; id_is_load = r.ld;
    redirect = r.redir; ihit = r.ih; dmem_req = r.dreq; dhit = r.dh;
  endtask

  initial begin
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO, 0));

    // A: LOAD_LAT=1, BR_RESOLVE=1
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 0, 0, RUN,  0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 1, 6, 0, 0, 1, 0, 0, HZ,   0));
    tbl.push_back(mk(0, 0, 1, 5, 1, 0, 0, 1, 6, 0, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 9, 1, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, RD1,  1));
    tbl.push_back(mk(0, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUN,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IMS,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, RUN,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, FRZ,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, RD1,  1));
    // B: LOAD_LAT=3, BR_RESOLVE=2 -- freeze mid-stall, then squash undo
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, RUN,  0));
    tbl.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ,   0));
    tbl.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  1));
    tbl.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, FRZ,  1));
    tbl.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ,   1));
    tbl.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ,   2));
    tbl.push_back(mk(1, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUN,  3));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 9, 1, 0, 1, 0, 0, RUN,  3));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, RD2,  3));
    tbl.push_back(mk(1, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUN,  3));
    // C: stall counter starts at FFFF_FFFE and must saturate
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO, 32'hFFFF_FFFE));
    tbl.push_back(mk(2, 0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 0, 0, RUN,  32'hFFFF_FFFE));
    tbl.push_back(mk(2, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ,   32'hFFFF_FFFE));
    tbl.push_back(mk(2, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ,   32'hFFFF_FFFF));
    tbl.push_back(mk(2, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ,   32'hFFFF_FFFF));
    tbl.push_back(mk(2, 0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUN,  32'hFFFF_FFFF));

    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d_ctl", i), {23'd0, ctl(tbl[i].sel)}, {23'd0, tbl[i].exp});
      chk($sformatf("row%0d_stall_cycles", i), sc_w[tbl[i].sel], tbl[i].sc);
    end

    // Asynchronous reset in the middle of a stall and in the middle of a freeze.
    @(negedge CLK);
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RSTO, 0));
    @(negedge CLK);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 0, 0, RUN, 0));
    @(negedge CLK);
    drive(mk(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ, 0));
    #1 chk("a_mid_stall_ctl", {23'd0, ctl(0)}, {23'd0, HZ});
    #2 RST = 1'b1;
    #1 chk("a_async_rst_ctl", {23'd0, ctl(0)}, {23'd0, RSTO});
    chk("a_async_rst_sc", sc_w[0], 32'd0);
    chk("c_async_rst_sc", sc_w[2], 32'hFFFF_FFFE);
    @(negedge CLK);
    RST = 1'b0; dmem_req = 1'b1; dhit = 1'b0;
    #1 chk("c_mid_freeze_ctl", {23'd0, ctl(2)}, {23'd0, FRZ});
    #2 RST = 1'b1;
    #1 chk("c_async_rst_frz_ctl", {23'd0, ctl(2)}, {23'd0, RSTO});
    @(negedge CLK);
    RST = 1'b0; dmem_req = 1'b0;
    #1 chk("a_after_rst_ctl", {23'd0, ctl(0)}, {23'd0, RUN});
    chk("c_after_rst_ctl", {23'd0, ctl(2)}, {23'd0, RUN});
    @(negedge CLK);
    #1 chk("a_after_rst_sc", sc_w[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Parametrised hazard controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB latches).
- Adds a per-register scoreboard of countdown counters, so producer latency is set by parameter rather than by a fixed load-use compare.
- Branch/jump resolve stage is selectable; memory-wait freeze and a saturating stall-cycle performance counter are included.
- Drives the enables/flushes of all four pipeline latches and the PC.

Parameters:
- REGW, 5, register index width; tracked registers are 1..2**REGW-1 (register 0 never tracked).
- MAX_LAT, 3, maximum producer latency; counter width CW = $clog2(MAX_LAT+1).
- LOAD_LAT, 1, cycles a load destination is unavailable after issue (0..MAX_LAT).
- ALU_LAT, 0, cycles a non-load destination is unavailable after issue (0..MAX_LAT).
- BR_RESOLVE, 1, stage where redirect is raised: 1 = EX, 2 = MEM.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction in decode
- id_rs, id_rt  in  REGW  decode source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_wen  in  1  decode instruction writes a register
- id_rd  in  REGW  decode destination register
- id_is_load  in  1  decode instruction is a load
- redirect  in  1  taken branch/jump/jr/jal at the resolve stage
- ihit  in  1  instruction fetch complete this cycle
- dmem_req  in  1  MEM stage has a data request
- dhit  in  1  data request complete
- pc_en  out  1  PC write enable
- fd_stall, fd_flush  out  1  IF/ID hold / bubble
- de_stall, de_flush  out  1  ID/EX hold / bubble
- em_stall, em_flush  out  1  EX/MEM hold / bubble
- mw_stall, mw_flush  out  1  MEM/WB hold / bubble
- stall_cycles  out  32  saturating count of load-use stall cycles

Behaviour:
- Reset (asynchronous) state: all counters 0, tag pipe invalid, stall_cycles 0.
- Outputs while RST high: pc_en=0, all *_stall=0, all *_flush=1.
- Outputs are combinational from state and inputs. Priority, highest first:
  - freeze = dmem_req && !dhit: all *_stall=1, pc_en=0, all flushes 0, state holds (no decrement, no issue, no count).
  - redirect (not frozen): pc_en=1, fd_flush=1, de_flush=1. If BR_RESOLVE=2, also em_flush=1. Decode instruction squashed (no issue).
  - hazard = id_valid && ((id_uses_rs && id_rs!=0 && cnt[id_rs]!=0) || (id_uses_rt && id_rt!=0 && cnt[id_rt]!=0)):
    - pc_en=0, fd_stall=1, de_flush=1, other stages advance.
    - stall_cycles += 1, saturating at 32'hFFFF_FFFF.
  - !ihit: pc_en=0, fd_flush=1 (bubble into decode), other stages advance.
  - Otherwise pc_en=1, all stalls and flushes 0.
- A redirect is raised from a frozen latch, so it persists through a freeze and is acted on in the first unfrozen cycle.
- issue = id_valid && !freeze && !redirect && !hazard.
- Counter update each unfrozen cycle:
  - Every nonzero counter decrements by 1.
  - Then, on issue with id_wen and id_rd!=0: cnt[id_rd] = id_is_load ? LOAD_LAT : ALU_LAT. This overwrites any older value; the write is applied after the decrement.
- Tag pipe, BR_RESOLVE=2 only, depth 1:
  - On each unfrozen cycle it captures {issue && id_wen && id_rd!=0, id_rd, cnt[id_rd] before this cycle's overwrite}.
  - On redirect with a valid tag, cnt[tag_rd] is restored to the saved previous value minus 1, saturating at 0. This replaces the normal update for that entry.
  - The tag is then invalidated.
- With BR_RESOLVE=1 the tag pipe is absent and redirect does not modify counters.
- Latency contract: a consumer in decode the cycle after a load issues stalls exactly LOAD_LAT cycles, absent freeze.
- A consumer reading register 0 never stalls. A source with id_uses_*=0 never stalls.
- Reset mid-freeze or mid-stall: immediate return to reset outputs; no partial state survives.

Test Plan:
- Load to r5 issues (LOAD_LAT=1); next cycle decode reads rs=5 -> exactly 1 cycle of pc_en=0, fd_stall=1, de_flush=1; stall_cycles=1; issue proceeds the following cycle.
- LOAD_LAT=3, consumer of r7 directly behind the load -> 3 stall cycles. Inject dmem_req=1, dhit=0 for 2 cycles mid-stall -> all stalls high, counter frozen, total load-use stalls still 3, stall_cycles=3.
- Consumer with rt=0, and a separate consumer with id_uses_rt=0 while r0/rt nominally pending -> no stall.
- BR_RESOLVE=1, redirect=1 with a hazard present -> fd_flush=de_flush=1, pc_en=1, em_flush=0, stall_cycles unchanged.
- BR_RESOLVE=2: load r9 issues, redirect next cycle -> em_flush=1, cnt[9] restored to 0; a following reader of r9 does not stall.
- Hazard held continuously with stall_cycles preset near 32'hFFFF_FFFE -> saturates at 32'hFFFF_FFFF. Assert RST mid-test -> outputs go to reset values asynchronously, before the next clock edge.
